// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, interrupt
// cause values, pipeline interrupt codes and mtvec mode encodings.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_TAKE   = 3'd2,
        ST_RET    = 3'd3,
        ST_SETTLE = 3'd4
    } trap_state_t;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam logic [1:0] INT_NONE = 2'b00;
    localparam logic [1:0] INT_TRAP = 2'b01;
    localparam logic [1:0] INT_MRET = 2'b10;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/trap_vector_calc.sv
// Combinational trap target: mtvec base, plus 4*cause code in vectored mode.
// Reserved modes 2/3 fall back to direct.
module trap_vector_calc
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mtvec,
    input  logic [3:0]      cause_code,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    always_comb begin
        base   = {mtvec[XLEN-1:2], 2'b00};
        offset = '0;
        if (mtvec[1:0] == MTVEC_VECTORED) begin
            offset = {{(XLEN-6){1'b0}}, cause_code, 2'b00};
        end
        target = base + offset;
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / mret return controller for the 3-stage RV32 pipeline.
// Qualifies interrupts, picks a safe stage-3 boundary, drives flush/redirect and CSR trap writes.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            mstatus_mie,
    input  logic            mie_meie,
    input  logic            mie_mtie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] pc_m,
    input  logic            instr_valid_m,
    input  logic            br_taken_m,
    input  logic            is_mret_m,
    output logic [1:0]      interrupt,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            csr_trap_we,
    output logic [XLEN-1:0] mepc_wdata,
    output logic [XLEN-1:0] mcause_wdata,
    output logic            csr_mret_we
);

    localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYC - 1);

    trap_state_t     state;
    logic [1:0]      settle_cnt;

    logic            ext_hit;
    logic            tmr_hit;
    logic            pending;
    logic [3:0]      take_code;
    logic [XLEN-1:0] take_cause;
    logic [XLEN-1:0] vec_target;

    assign ext_hit    = ext_irq & mie_meie;
    assign tmr_hit    = timer_irq & mie_mtie;
    assign pending    = mstatus_mie & (ext_hit | tmr_hit);
    assign take_code  = ext_hit ? CAUSE_MEI[3:0] : CAUSE_MTI[3:0];
    assign take_cause = {1'b1, {(XLEN-5){1'b0}}, take_code};

    trap_vector_calc #(
        .XLEN(XLEN)
    ) u_vector_calc (
        .mtvec      (mtvec),
        .cause_code (take_code),
        .target     (vec_target)
    );

    // TAKE and RET are single-cycle pulses: the CSR file and PC mux accept
    // them unconditionally, so there is no ready/backpressure path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            settle_cnt     <= 2'd0;
            interrupt      <= INT_NONE;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            csr_trap_we    <= 1'b0;
            csr_mret_we    <= 1'b0;
            mepc_wdata     <= '0;
            mcause_wdata   <= '0;
        end else begin
            interrupt      <= INT_NONE;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            csr_trap_we    <= 1'b0;
            csr_mret_we    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (is_mret_m) begin
                        state          <= ST_RET;
                        interrupt      <= INT_MRET;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        csr_mret_we    <= 1'b1;
                        redirect_pc    <= mepc;
                    end else if (pending) begin
                        state        <= ST_ARMED;
                        mcause_wdata <= take_cause;
                    end
                end

                ST_ARMED: begin
                    if (!pending) begin
                        state <= ST_IDLE;
                    end else if (is_mret_m) begin
                        state          <= ST_RET;
                        interrupt      <= INT_MRET;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        csr_mret_we    <= 1'b1;
                        redirect_pc    <= mepc;
                    end else if (instr_valid_m && !br_taken_m) begin
                        // Cause is re-sampled so a late higher-priority source wins.
                        state          <= ST_TAKE;
                        interrupt      <= INT_TRAP;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        csr_trap_we    <= 1'b1;
                        redirect_pc    <= vec_target;
                        mepc_wdata     <= pc_m;
                        mcause_wdata   <= take_cause;
                    end
                end

                ST_TAKE, ST_RET: begin
                    state      <= ST_SETTLE;
                    flush      <= 1'b1;
                    settle_cnt <= SETTLE_LOAD;
                end

                ST_SETTLE: begin
                    if (settle_cnt == 2'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 2'd1;
                        flush      <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
